// File: rtl/ptcalc_ch_scheduler_pkg.sv
// ptcalc_ch_scheduler_pkg: shared sizes and the PL2MTC grant bundle
package ptcalc_ch_scheduler_pkg;
    localparam int MTC_PER_BCID = 3;
    localparam int TOTAL_PTCALC_BLKS = 3;
    localparam int PL2MTC_PROCESS_CH_LEN = 2;
    typedef struct packed {
        logic valid;
        logic busy;
        logic [PL2MTC_PROCESS_CH_LEN-1:0] ch;
    } pl2mtc_grant_t;
endpackage

// File: rtl/ptcalc_blk_tracker.sv
// ptcalc_blk_tracker: busy flag and watchdog timer for one ptcalc block
module ptcalc_blk_tracker
    import ptcalc_ch_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic rst,
    input  logic grant,
    input  logic done,
    output logic busy,
    output logic timeout_pulse,
    output logic spurious
);
    localparam int TMR_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [TMR_W-1:0] timer;
    // a done on the expiry cycle suppresses the timeout
    assign timeout_pulse = busy && !done && TIMEOUT != 0 && timer == TMR_W'(TIMEOUT - 1);
    assign spurious = done && !busy;
    always_ff @(posedge clock) begin
        if (rst) begin
            busy <= 1'b0;
            timer <= '0;
        end else if (grant) begin
            busy <= 1'b1;
            timer <= '0;
        end else if (busy && (done || timeout_pulse)) begin
            busy <= 1'b0;
            timer <= '0;
        end else if (busy) begin
            timer <= timer + 1'b1;
        end
    end
endmodule

// File: rtl/ptcalc_ch_scheduler.sv
// ptcalc_ch_scheduler: round-robin assignment of free ptcalc blocks to sector-logic candidates
module ptcalc_ch_scheduler
    import ptcalc_ch_scheduler_pkg::*;
#(
    parameter int N_SLC = MTC_PER_BCID,
    parameter int N_BLK = TOTAL_PTCALC_BLKS,
    parameter int CH_W = PL2MTC_PROCESS_CH_LEN,
    parameter int TIMEOUT = 64,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N_SLC-1:0]      slc_valid,
    input  logic [N_BLK-1:0]      ptcalc_done,
    output logic [N_SLC-1:0]      grant_valid,
    output logic [N_SLC-1:0]      grant_busy,
    output logic [N_SLC*CH_W-1:0] grant_ch,
    output logic [N_BLK-1:0]      blk_busy,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [CNT_W-1:0]      timeout_cnt,
    output logic                  spurious_done
);
    logic [N_BLK-1:0] taken, spur, tmo;
    logic [N_SLC-1:0] g_busy;
    logic [N_SLC*CH_W-1:0] g_ch;
    logic [CH_W-1:0] rr_ptr, last, j;
    logic [CH_W:0] jj;
    logic [CNT_W-1:0] drops, tmos;
    logic [CNT_W:0] drop_sum, tmo_sum;
    logic hit;
    // each slot scans from rr_ptr, skipping blocks already taken this cycle
    always_comb begin
        taken = '0;
        g_busy = '0;
        g_ch = '0;
        drops = '0;
        last = rr_ptr;
        j = '0;
        jj = '0;
        hit = 1'b0;
        for (int i = 0; i < N_SLC; i++) begin
            hit = 1'b0;
            for (int k = 0; k < N_BLK; k++) begin
                jj = {1'b0, rr_ptr} + (CH_W+1)'(k);
                jj = jj >= (CH_W+1)'(N_BLK) ? jj - (CH_W+1)'(N_BLK) : jj;
                j = jj[CH_W-1:0];
                if (!hit && enable && slc_valid[i] && !blk_busy[j] && !taken[j]) begin
                    hit = 1'b1;
                    taken[j] = 1'b1;
                    g_ch[i*CH_W +: CH_W] = j;
                    last = j;
                end
            end
            g_busy[i] = hit;
            drops = slc_valid[i] && !hit ? drops + CNT_W'(1) : drops;
        end
    end
    always_comb begin
        tmos = '0;
        for (int i = 0; i < N_BLK; i++) tmos = tmos + CNT_W'(tmo[i]);
    end
    assign drop_sum = {1'b0, drop_cnt} + {1'b0, drops};
    assign tmo_sum = {1'b0, timeout_cnt} + {1'b0, tmos};
    for (genvar b = 0; b < N_BLK; b++) begin : g_trk
        ptcalc_blk_tracker #(.TIMEOUT(TIMEOUT)) u_trk (
            .clock(clock),
            .rst(rst),
            .grant(taken[b]),
            .done(ptcalc_done[b]),
            .busy(blk_busy[b]),
            .timeout_pulse(tmo[b]),
            .spurious(spur[b])
        );
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            grant_valid <= '0;
            grant_busy <= '0;
            grant_ch <= '0;
            rr_ptr <= '0;
            drop_cnt <= '0;
            timeout_cnt <= '0;
            spurious_done <= 1'b0;
        end else begin
            grant_valid <= slc_valid;
            grant_busy <= g_busy;
            grant_ch <= g_ch;
            rr_ptr <= |taken ? (last == CH_W'(N_BLK - 1) ? '0 : last + 1'b1) : rr_ptr;
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            timeout_cnt <= tmo_sum[CNT_W] ? '1 : tmo_sum[CNT_W-1:0];
            spurious_done <= |spur;
        end
    end
endmodule

// File: tb/tb_ptcalc_ch_scheduler.sv
// tb_ptcalc_ch_scheduler: random and directed stimulus against a free-list reference model
module tb_ptcalc_ch_scheduler;
    localparam int TO = 4;
    logic clock = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [2:0] slc_valid = '0, ptcalc_done = '0;
    logic [2:0] grant_valid, grant_busy, blk_busy;
    logic [5:0] grant_ch;
    logic [15:0] drop_cnt, timeout_cnt;
    logic spurious_done;
    int total = 0, bad = 0;
    int mb[3], age[3], rr, mdrop, mtmo;
    logic [2:0] e_gv, e_gb, e_bb;
    logic [5:0] e_gch;
    logic e_sp;

    always #5 clock = ~clock;

    ptcalc_ch_scheduler #(.TIMEOUT(TO)) dut (
        .clock(clock), .rst(rst), .enable(enable), .slc_valid(slc_valid),
        .ptcalc_done(ptcalc_done), .grant_valid(grant_valid), .grant_busy(grant_busy),
        .grant_ch(grant_ch), .blk_busy(blk_busy), .drop_cnt(drop_cnt),
        .timeout_cnt(timeout_cnt), .spurious_done(spurious_done)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    // free blocks listed in rr order; the n-th valid slot takes the n-th entry
    task automatic model_step(input logic r, input logic en, input logic [2:0] v, input logic [2:0] d);
        int fl[$];
        int n, last;
        logic [2:0] gr;
        if (r) begin
            for (int b = 0; b < 3; b++) begin mb[b] = 0; age[b] = 0; end
            rr = 0; mdrop = 0; mtmo = 0;
            e_gv = 0; e_gb = 0; e_gch = 0; e_bb = 0; e_sp = 0;
            return;
        end
        for (int k = 0; k < 3; k++) if (mb[(rr + k) % 3] == 0) fl.push_back((rr + k) % 3);
        n = 0; last = 0; gr = 0; e_gb = 0; e_gch = 0; e_sp = 0;
        for (int s = 0; s < 3; s++) begin
            if (v[s]) begin
                if (en && n < fl.size()) begin
                    gr[fl[n]] = 1'b1;
                    e_gb[s] = 1'b1;
                    e_gch[s*2 +: 2] = 2'(fl[n]);
                    last = fl[n];
                    n++;
                end else mdrop = mdrop < 65535 ? mdrop + 1 : 65535;
            end
        end
        for (int b = 0; b < 3; b++) begin
            if (d[b] && mb[b] == 0) e_sp = 1'b1;
            if (gr[b]) begin mb[b] = 1; age[b] = 0; end
            else if (mb[b] != 0) begin
                if (d[b]) mb[b] = 0;
                else if (age[b] == TO - 1) begin mb[b] = 0; mtmo = mtmo < 65535 ? mtmo + 1 : 65535; end
                else age[b]++;
            end
            e_bb[b] = mb[b] != 0;
        end
        if (n > 0) rr = (last + 1) % 3;
        e_gv = v;
    endtask

    task automatic step(input logic r, input logic en, input logic [2:0] v, input logic [2:0] d);
        rst = r; enable = en; slc_valid = v; ptcalc_done = d;
        model_step(r, en, v, d);
        @(posedge clock);
        #1;
        chk("grant_valid", grant_valid, e_gv);
        chk("grant_busy", grant_busy, e_gb);
        chk("grant_ch", grant_ch, e_gch);
        chk("blk_busy", blk_busy, e_bb);
        chk("drop_cnt", drop_cnt, mdrop);
        chk("timeout_cnt", timeout_cnt, mtmo);
        chk("spurious_done", spurious_done, e_sp);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_outputs", {grant_valid, grant_busy, grant_ch, blk_busy, spurious_done}, 0);
        chk("rst_cnts", {drop_cnt, timeout_cnt}, 0);
        step(0, 1, 3'b001, 0);
        chk("t1_busy", grant_busy, 3'b001);
        chk("t1_ch", grant_ch, 0);
        chk("t1_blk", blk_busy, 3'b001);
        step(0, 1, 0, 3'b001);
        chk("t2_idle", blk_busy, 0);
        step(0, 1, 3'b111, 0);
        chk("t2_busy", grant_busy, 3'b111);
        chk("t2_ch", grant_ch, 6'b00_10_01);
        chk("t2_blk", blk_busy, 3'b111);
        step(0, 1, 3'b101, 0);
        chk("t3_nogrant", grant_busy, 0);
        chk("t3_drop", drop_cnt, 2);
        step(0, 1, 0, 3'b010);
        chk("t3_done", blk_busy, 3'b101);
        step(0, 1, 3'b001, 0);
        chk("t3_ch", grant_ch, 6'b00_00_01);
        chk("t3_blk", blk_busy, 3'b111);
        repeat (5) step(0, 1, 0, 0);
        chk("drain_blk", blk_busy, 0);
        chk("drain_tmo", timeout_cnt, 3);
        step(0, 1, 3'b001, 0);
        chk("t4_ch", grant_ch, 6'b00_00_10);
        repeat (3) begin
            step(0, 1, 0, 0);
            chk("t4_hold", blk_busy, 3'b100);
        end
        step(0, 1, 0, 0);
        chk("t4_expire", blk_busy, 0);
        chk("t4_tmo", timeout_cnt, 4);
        step(0, 1, 3'b001, 0);
        chk("t4b_blk", blk_busy, 3'b001);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 0, 3'b001);
        chk("t4b_blk_clr", blk_busy, 0);
        chk("t4b_tmo", timeout_cnt, 4);
        chk("t4b_sp", spurious_done, 0);
        step(0, 1, 0, 3'b100);
        chk("t5_sp", spurious_done, 1);
        step(0, 1, 0, 0);
        chk("t5_sp_pulse", spurious_done, 0);
        step(0, 0, 3'b111, 0);
        chk("t5_dis_busy", grant_busy, 0);
        chk("t5_dis_drop", drop_cnt, 5);
        repeat (3000) begin
            step(($urandom % 150) == 0, ($urandom % 8) != 0, 3'($urandom % 8),
                 {($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0});
        end
        step(1, 0, 0, 0);
        repeat (21845) step(0, 0, 3'b111, 0);
        chk("t6_sat", drop_cnt, 16'hFFFF);
        step(0, 0, 3'b111, 0);
        chk("t6_sat_hold", drop_cnt, 16'hFFFF);
        step(0, 1, 3'b111, 0);
        chk("t6_full", blk_busy, 3'b111);
        step(1, 0, 0, 0);
        chk("t6_rst_blk", blk_busy, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_grant", {grant_valid, grant_busy, grant_ch}, 0);
        step(0, 1, 0, 3'b111);
        chk("t6_spurious", spurious_done, 1);
        chk("t6_still_idle", blk_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
